// File: rtl/seg_data_mem_dump_pkg.sv
// rtl/seg_data_mem_dump_pkg.sv - shared constants and state encoding for the data-memory dump
package seg_data_mem_dump_pkg;

    localparam int LEN            = 32;
    localparam int NB_BYTE        = 8;
    localparam int BYTES_PER_WORD = LEN / NB_BYTE;

    // Read latency of the data memory debug port; the memory instance uses the same values.
    localparam int LOW_LATENCY    = 1;
    localparam int HIGH_LATENCY   = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        WAIT_RD = 3'd2,
        SEND    = 3'd3,
        WAIT_TX = 3'd4,
        DONE    = 3'd5
    } dump_state_t;

endpackage

// File: rtl/seg_data_mem_dump_if.sv
// rtl/seg_data_mem_dump_if.sv - memory read port, byte transmitter and control signals of the dump block
interface seg_data_mem_dump_if #(
    parameter int LEN          = 32,
    parameter int NB_BYTE      = 8,
    parameter int NB_DATA_ADDR = 5
);
    logic                    i_start;
    logic [LEN-1:0]          i_mem_data;
    logic [NB_DATA_ADDR-1:0] o_mem_addr;
    logic                    o_mem_rd_en;
    logic [NB_BYTE-1:0]      o_tx_data;
    logic                    o_tx_start;
    logic                    i_tx_done;
    logic                    o_busy;
    logic                    o_done;

    // The dump block drives the memory address and the transmitter.
    modport master (
        input  i_start, i_mem_data, i_tx_done,
        output o_mem_addr, o_mem_rd_en, o_tx_data, o_tx_start, o_busy, o_done
    );

    // Memory, transmitter and debug controller around the dump block.
    modport slave (
        output i_start, i_mem_data, i_tx_done,
        input  o_mem_addr, o_mem_rd_en, o_tx_data, o_tx_start, o_busy, o_done
    );
endinterface

// File: rtl/seg_data_mem_dump_word_byte_serializer.sv
// rtl/seg_data_mem_dump_word_byte_serializer.sv - splits one captured word into MSB-first transmit bytes
module seg_data_mem_dump_word_byte_serializer
    import seg_data_mem_dump_pkg::*;
#(
    parameter int LEN     = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic [LEN-1:0]     i_word,
    input  logic               i_wait_tx,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_byte_done,
    output logic               o_word_done
);
    localparam int WORD_BYTES = LEN / NB_BYTE;
    localparam int NB_IDX     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    logic [LEN-1:0]    word_q;
    logic [NB_IDX-1:0] idx_q;
    logic [LEN-1:0]    word_src;
    logic [NB_IDX-1:0] idx_src;
    logic              ack;
    logic              step;

    // A transmitter acknowledge only counts while waiting for it.
    assign ack         = i_wait_tx & i_tx_done;
    assign o_byte_done = ack & (idx_q != '0);
    assign o_word_done = ack & (idx_q == '0);
    assign step        = i_load | o_byte_done;

    // Word and index feeding the next SEND: a fresh word starts at its top byte.
    always_comb begin
        word_src = word_q;
        idx_src  = idx_q - 1'b1;
        if (i_load) begin
            word_src = i_word;
            idx_src  = NB_IDX'(WORD_BYTES - 1);
        end
    end

    // Word register and byte index advance on capture and on each intermediate acknowledge.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (step) begin
            word_q <= word_src;
            idx_q  <= idx_src;
        end
    end

    // Registered strobe and byte; the byte holds until the next SEND.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
        end else begin
            o_tx_start <= step;
            if (step) begin
                o_tx_data <= word_src[idx_src*NB_BYTE +: NB_BYTE];
            end
        end
    end

endmodule

// File: rtl/seg_data_mem_dump.sv
// rtl/seg_data_mem_dump.sv - walks data memory and streams every word to the byte transmitter
module seg_data_mem_dump #(
    parameter int LEN            = seg_data_mem_dump_pkg::LEN,
    parameter int NB_BYTE        = seg_data_mem_dump_pkg::NB_BYTE,
    parameter int RAM_DEPTH_DATA = 21,
    parameter int NB_DATA_ADDR   = 5,
    parameter int READ_LATENCY   = seg_data_mem_dump_pkg::LOW_LATENCY
) (
    input  logic                i_clk,
    input  logic                i_rst,
    seg_data_mem_dump_if.master bus
);
    import seg_data_mem_dump_pkg::*;

    dump_state_t             state_q;
    dump_state_t             state_d;
    logic [NB_DATA_ADDR-1:0] addr_q;
    logic [1:0]              lat_q;
    logic                    rd_en_q;
    logic                    done_q;
    logic                    load;
    logic                    byte_done;
    logic                    word_done;
    logic                    last_word;

    assign load      = (state_q == WAIT_RD) && (lat_q == 2'd0);
    assign last_word = (addr_q == NB_DATA_ADDR'(RAM_DEPTH_DATA - 1));

    assign bus.o_mem_addr  = addr_q;
    assign bus.o_mem_rd_en = rd_en_q;
    assign bus.o_done      = done_q;
    assign bus.o_busy      = (state_q != IDLE);

    seg_data_mem_dump_word_byte_serializer #(
        .LEN     (LEN),
        .NB_BYTE (NB_BYTE)
    ) u_serializer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (load),
        .i_word      (bus.i_mem_data),
        .i_wait_tx   (state_q == WAIT_TX),
        .i_tx_done   (bus.i_tx_done),
        .o_tx_start  (bus.o_tx_start),
        .o_tx_data   (bus.o_tx_data),
        .o_byte_done (byte_done),
        .o_word_done (word_done)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: read cycle, latency wait, byte handshake, stop after the last word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.i_start) state_d = READ;
            READ:    state_d = WAIT_RD;
            WAIT_RD: if (lat_q == 2'd0) state_d = SEND;
            SEND:    state_d = WAIT_TX;
            WAIT_TX: begin
                if (byte_done) begin
                    state_d = SEND;
                end else if (word_done) begin
                    state_d = last_word ? DONE : READ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Word address and memory latency counter.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            addr_q <= '0;
            lat_q  <= 2'd0;
        end else begin
            if ((state_q == IDLE) && bus.i_start) begin
                addr_q <= '0;
            end else if (word_done && !last_word) begin
                addr_q <= addr_q + 1'b1;
            end
            if (state_q == READ) begin
                lat_q <= 2'(READ_LATENCY - 1);
            end else if ((state_q == WAIT_RD) && (lat_q != 2'd0)) begin
                lat_q <= lat_q - 2'd1;
            end
        end
    end

    // Registered read strobe and completion pulse, high exactly while in READ / DONE.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            rd_en_q <= (state_d == READ);
            done_q  <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_seg_data_mem_dump.sv
// tb/tb_seg_data_mem_dump.sv - self-checking bench for seg_data_mem_dump at both read latencies
module tb_seg_data_mem_dump;
    import seg_data_mem_dump_pkg::*;

    localparam int DEPTH  = 21;
    localparam int NBYTES = 4 * DEPTH;

    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int vec = 0;
    int err = 0;

    seg_data_mem_dump_if #(.LEN(32), .NB_BYTE(8), .NB_DATA_ADDR(5)) bus0 ();
    seg_data_mem_dump_if #(.LEN(32), .NB_BYTE(8), .NB_DATA_ADDR(5)) bus1 ();

    seg_data_mem_dump #(.LEN(32), .NB_BYTE(8), .RAM_DEPTH_DATA(DEPTH), .NB_DATA_ADDR(5),
                        .READ_LATENCY(LOW_LATENCY)) dut0 (.i_clk(i_clk), .i_rst(i_rst), .bus(bus0.master));
    seg_data_mem_dump #(.LEN(32), .NB_BYTE(8), .RAM_DEPTH_DATA(DEPTH), .NB_DATA_ADDR(5),
                        .READ_LATENCY(HIGH_LATENCY)) dut1 (.i_clk(i_clk), .i_rst(i_rst), .bus(bus1.master));

    logic        start_v [2];
    logic        resp_v  [2];
    logic        spur_v  [2];
    logic [31:0] mem [0:31];
    logic [31:0] m0, m1a, m1b;
    int          rand_dly = 0;
    int          fix_dly  = 4;
    logic [7:0]  exp_q [$];

    assign bus0.i_start    = start_v[0];
    assign bus1.i_start    = start_v[1];
    assign bus0.i_tx_done  = resp_v[0] | spur_v[0];
    assign bus1.i_tx_done  = resp_v[1] | spur_v[1];
    assign bus0.i_mem_data = m0;
    assign bus1.i_mem_data = m1b;

    logic [4:0] addr_w [2];
    logic       rd_en_w [2], tx_start_w [2], busy_w [2], done_w [2], txdone_w [2];
    logic [7:0] tx_data_w [2];
    always_comb begin
        addr_w[0] = bus0.o_mem_addr;   addr_w[1] = bus1.o_mem_addr;
        rd_en_w[0] = bus0.o_mem_rd_en; rd_en_w[1] = bus1.o_mem_rd_en;
        tx_start_w[0] = bus0.o_tx_start; tx_start_w[1] = bus1.o_tx_start;
        tx_data_w[0] = bus0.o_tx_data; tx_data_w[1] = bus1.o_tx_data;
        busy_w[0] = bus0.o_busy;       busy_w[1] = bus1.o_busy;
        done_w[0] = bus0.o_done;       done_w[1] = bus1.o_done;
        txdone_w[0] = bus0.i_tx_done;  txdone_w[1] = bus1.i_tx_done;
    end

    // Synchronous memory models: one and two cycles from read strobe to data.
    always @(posedge i_clk) begin
        if (bus0.o_mem_rd_en) m0 <= mem[bus0.o_mem_addr];
        if (bus1.o_mem_rd_en) m1a <= mem[bus1.o_mem_addr];
        m1b <= m1a;
    end

    // Byte capture and completion bookkeeping.
    logic [7:0] cap [2][0:4095];
    int cap_n [2]     = '{0, 0};
    int done_n [2]    = '{0, 0};
    int done_cyc [2]  = '{0, 0};
    int done_at_n [2] = '{0, 0};
    int txd_cyc [2]   = '{0, 0};
    always @(negedge i_clk) begin
        for (int d = 0; d < 2; d++) begin
            if (tx_start_w[d] === 1'b1) begin
                if (cap_n[d] < 4096) cap[d][cap_n[d]] <= tx_data_w[d];
                cap_n[d] <= cap_n[d] + 1;
            end
            if (done_w[d] === 1'b1) begin
                done_n[d]    <= done_n[d] + 1;
                done_cyc[d]  <= cyc;
                done_at_n[d] <= cap_n[d];
            end
            if (txdone_w[d] === 1'b1) txd_cyc[d] <= cyc;
        end
    end

    // Transmitter model: acknowledge a fixed or random number of cycles after each strobe.
    initial begin
        int cnt [2];
        cnt = '{0, 0};
        resp_v = '{1'b0, 1'b0};
        forever begin
            @(posedge i_clk); #1;
            for (int d = 0; d < 2; d++) begin
                logic fire;
                fire = 1'b0;
                if (cnt[d] != 0) begin
                    cnt[d]--;
                    if (cnt[d] == 0) fire = 1'b1;
                end
                if (tx_start_w[d] === 1'b1) cnt[d] = (rand_dly != 0) ? int'($urandom_range(1, 6)) : fix_dly;
                resp_v[d] = fire;
            end
        end
    end

    task automatic fill_fixed();
        for (int n = 0; n < 32; n++) begin
            logic [7:0] b;
            b = n[7:0];
            mem[n] = (n < DEPTH) ? {4{b}} : $urandom();
        end
        mem[1] = 32'hF6F6F6F6;
        mem[8] = 32'hA5DFA5DF;
    endtask

    task automatic fill_random();
        for (int n = 0; n < 32; n++) mem[n] = $urandom();
    endtask

    // Reference stream: every word in address order, most significant byte first.
    task automatic build_exp();
        exp_q.delete();
        for (int n = 0; n < DEPTH; n++) begin
            logic [31:0] w;
            w = mem[n];
            exp_q.push_back(w[31:24]);
            exp_q.push_back(w[23:16]);
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
        end
    endtask

    function automatic int stream_bad(input int d, input int base, output int first);
        int bad = 0;
        first = -1;
        for (int i = 0; i < NBYTES; i++) begin
            if (cap[d][base + i] !== exp_q[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        return bad;
    endfunction

    function automatic logic [16:0] outs(input int d);
        return {addr_w[d], rd_en_w[d], tx_data_w[d], tx_start_w[d], busy_w[d], done_w[d]};
    endfunction

    task automatic pulse_start(input int d, output int t);
        @(posedge i_clk); #1;
        start_v[d] = 1'b1;
        t = cyc;
        @(posedge i_clk); #1;
        start_v[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int base, output bit to);
        int k = 0;
        while (done_n[d] == base && k < 3000) begin
            @(negedge i_clk);
            k++;
        end
        to = (done_n[d] == base);
        repeat (5) @(negedge i_clk);
    endtask

    task automatic test_reset();
        logic [16:0] obs;
        i_rst = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            for (int d = 0; d < 2; d++) begin
                obs = outs(d);
                vec++;
                if (obs !== 17'd0) begin err++; $display("FAIL reset_hold dut%0d: outputs %h want 0", d, obs); end
            end
        end
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        repeat (10) begin
            @(negedge i_clk);
            for (int d = 0; d < 2; d++) begin
                obs = outs(d);
                vec++;
                if (obs !== 17'd0) begin err++; $display("FAIL reset_idle dut%0d: outputs %h want 0", d, obs); end
            end
        end
    endtask

    task automatic test_full_dump();
        int t, base, dbase, bad, first;
        bit to;
        logic [7:0] spot_v [8];
        int         spot_i [8];
        spot_v = '{8'hF6, 8'hF6, 8'hF6, 8'hF6, 8'hA5, 8'hDF, 8'hA5, 8'hDF};
        spot_i = '{4, 5, 6, 7, 32, 33, 34, 35};
        fill_fixed(); build_exp();
        rand_dly = 0; fix_dly = 4;
        base = cap_n[0]; dbase = done_n[0];
        pulse_start(0, t);
        wait_done(0, dbase, to);
        vec++;
        if (to) begin err++; $display("FAIL full_timeout: no o_done within bound"); end
        vec++;
        if (cap_n[0] - base !== NBYTES) begin err++; $display("FAIL full_count: %0d bytes want %0d", cap_n[0] - base, NBYTES); end
        bad = stream_bad(0, base, first);
        vec++;
        if (bad !== 0) begin err++; $display("FAIL full_stream: %0d bad bytes, first at %0d got %h want %h", bad, first, cap[0][base + first], exp_q[first]); end
        for (int i = 0; i < 8; i++) begin
            vec++;
            if (cap[0][base + spot_i[i]] !== spot_v[i]) begin
                err++; $display("FAIL full_spot byte %0d: got %h want %h", spot_i[i], cap[0][base + spot_i[i]], spot_v[i]);
            end
        end
        vec++;
        if (cap[0][base + NBYTES - 1] !== 8'h14) begin err++; $display("FAIL full_last: got %h want 14", cap[0][base + NBYTES - 1]); end
        vec++;
        if (done_n[0] - dbase !== 1) begin err++; $display("FAIL full_done_count: %0d want 1", done_n[0] - dbase); end
        vec++;
        if (done_at_n[0] - base !== NBYTES) begin err++; $display("FAIL full_done_order: done after %0d bytes want %0d", done_at_n[0] - base, NBYTES); end
        vec++;
        if (done_cyc[0] !== txd_cyc[0] + 1) begin err++; $display("FAIL full_done_cycle: cycle %0d want %0d", done_cyc[0], txd_cyc[0] + 1); end
        vec++;
        if (busy_w[0] !== 1'b0) begin err++; $display("FAIL full_busy_after: %b want 0", busy_w[0]); end
    endtask

    task automatic test_timing(input int d);
        int t, base, dbase, bad, first, k, rl;
        bit to;
        rl = (d == 0) ? 1 : 2;
        fill_random(); build_exp();
        rand_dly = 1;
        base = cap_n[d]; dbase = done_n[d];
        pulse_start(d, t);
        @(negedge i_clk);
        vec++;
        if (rd_en_w[d] !== 1'b1 || addr_w[d] !== 5'd0 || busy_w[d] !== 1'b1) begin
            err++; $display("FAIL timing_read dut%0d: rd_en %b addr %0d busy %b want 1 0 1", d, rd_en_w[d], addr_w[d], busy_w[d]);
        end
        k = 0;
        while (tx_start_w[d] !== 1'b1 && k < 50) begin @(negedge i_clk); k++; end
        vec++;
        if (cyc !== t + 2 + rl) begin err++; $display("FAIL timing_first_tx dut%0d: cycle %0d want %0d", d, cyc - t, 2 + rl); end
        wait_done(d, dbase, to);
        bad = stream_bad(d, base, first);
        vec++;
        if (to || bad !== 0) begin err++; $display("FAIL timing_stream dut%0d: timeout %b, %0d bad bytes", d, to, bad); end
        vec++;
        if (done_n[d] - dbase !== 1) begin err++; $display("FAIL timing_done dut%0d: %0d want 1", d, done_n[d] - dbase); end
        rand_dly = 0;
    endtask

    task automatic test_robustness();
        int t, base, dbase, bad, first, n, k;
        bit to;
        fill_fixed(); build_exp();
        rand_dly = 0; fix_dly = 4;
        base = cap_n[0]; dbase = done_n[0];
        @(posedge i_clk); #3; spur_v[0] = 1'b1;
        @(posedge i_clk); #3; spur_v[0] = 1'b0;
        @(negedge i_clk);
        vec++;
        if (busy_w[0] !== 1'b0) begin err++; $display("FAIL robust_idle_done: busy %b want 0", busy_w[0]); end
        pulse_start(0, t);
        @(posedge i_clk); #3; spur_v[0] = 1'b1;
        @(posedge i_clk); #3; spur_v[0] = 1'b0;
        n = 0; k = 0;
        while (n < 6 && k < 500) begin
            @(posedge i_clk); #1;
            if (tx_start_w[0] === 1'b1) n++;
            k++;
        end
        #2; spur_v[0] = 1'b1;
        @(posedge i_clk); #3; spur_v[0] = 1'b0;
        @(posedge i_clk); #1; start_v[0] = 1'b1;
        @(posedge i_clk); #1; start_v[0] = 1'b0;
        wait_done(0, dbase, to);
        bad = stream_bad(0, base, first);
        vec++;
        if (to || bad !== 0) begin err++; $display("FAIL robust_stream: timeout %b, %0d bad bytes, first %0d", to, bad, first); end
        vec++;
        if (cap_n[0] - base !== NBYTES) begin err++; $display("FAIL robust_count: %0d want %0d", cap_n[0] - base, NBYTES); end
        repeat (30) @(negedge i_clk);
        vec++;
        if (done_n[0] - dbase !== 1 || busy_w[0] !== 1'b0) begin
            err++; $display("FAIL robust_done_once: done %0d busy %b want 1 0", done_n[0] - dbase, busy_w[0]);
        end
    endtask

    task automatic test_reset_mid_dump();
        int t, base, dbase, bad, first, k;
        bit to;
        logic [16:0] obs;
        fill_fixed(); build_exp();
        rand_dly = 0; fix_dly = 4;
        base = cap_n[0]; dbase = done_n[0];
        pulse_start(0, t);
        k = 0;
        while (cap_n[0] - base < 21 && k < 1000) begin @(negedge i_clk); k++; end
        @(posedge i_clk); #2;
        i_rst = 1'b0;
        #1;
        obs = outs(0);
        vec++;
        if (obs !== 17'd0) begin err++; $display("FAIL abort_outputs: %h want 0", obs); end
        @(posedge i_clk); @(posedge i_clk); #1;
        i_rst = 1'b1;
        repeat (10) @(negedge i_clk);
        vec++;
        if (done_n[0] !== dbase || busy_w[0] !== 1'b0) begin
            err++; $display("FAIL abort_no_done: done %0d busy %b want 0 0", done_n[0] - dbase, busy_w[0]);
        end
        base = cap_n[0]; dbase = done_n[0];
        pulse_start(0, t);
        @(negedge i_clk);
        vec++;
        if (rd_en_w[0] !== 1'b1 || addr_w[0] !== 5'd0) begin err++; $display("FAIL abort_restart_addr: rd_en %b addr %0d want 1 0", rd_en_w[0], addr_w[0]); end
        wait_done(0, dbase, to);
        bad = stream_bad(0, base, first);
        vec++;
        if (to || bad !== 0) begin err++; $display("FAIL abort_restart_stream: timeout %b, %0d bad bytes", to, bad); end
        vec++;
        if (done_n[0] - dbase !== 1) begin err++; $display("FAIL abort_restart_done: %0d want 1", done_n[0] - dbase); end
    endtask

    task automatic test_latency2();
        int t, base, dbase, bad, first, k;
        bit to;
        fill_fixed(); build_exp();
        rand_dly = 0; fix_dly = 4;
        base = cap_n[1]; dbase = done_n[1];
        pulse_start(1, t);
        @(negedge i_clk);
        k = 0;
        while (tx_start_w[1] !== 1'b1 && k < 50) begin @(negedge i_clk); k++; end
        vec++;
        if (cyc !== t + 4) begin err++; $display("FAIL lat2_first_tx: cycle %0d want 4", cyc - t); end
        wait_done(1, dbase, to);
        bad = stream_bad(1, base, first);
        vec++;
        if (to || bad !== 0) begin err++; $display("FAIL lat2_stream: timeout %b, %0d bad bytes, first %0d", to, bad, first); end
        vec++;
        if (cap[1][base + 35] !== 8'hDF || cap[1][base + NBYTES - 1] !== 8'h14) begin
            err++; $display("FAIL lat2_spot: byte35 %h last %h want DF 14", cap[1][base + 35], cap[1][base + NBYTES - 1]);
        end
        vec++;
        if (done_n[1] - dbase !== 1 || done_cyc[1] !== txd_cyc[1] + 1) begin
            err++; $display("FAIL lat2_done: count %0d cycle %0d want 1 %0d", done_n[1] - dbase, done_cyc[1], txd_cyc[1] + 1);
        end
    endtask

    task automatic test_random();
        int t, base, dbase, bad, first;
        bit to;
        for (int it = 0; it < 3; it++) begin
            for (int d = 0; d < 2; d++) begin
                fill_random(); build_exp();
                rand_dly = 1;
                base = cap_n[d]; dbase = done_n[d];
                pulse_start(d, t);
                wait_done(d, dbase, to);
                bad = stream_bad(d, base, first);
                vec++;
                if (to || bad !== 0 || cap_n[d] - base !== NBYTES || done_n[d] - dbase !== 1) begin
                    err++; $display("FAIL random_dump it%0d dut%0d: timeout %b bad %0d bytes %0d done %0d", it, d, to, bad, cap_n[d] - base, done_n[d] - dbase);
                end
            end
        end
        rand_dly = 0;
    endtask

    initial begin
        start_v = '{1'b0, 1'b0};
        spur_v  = '{1'b0, 1'b0};
        i_rst   = 1'b0;
        test_reset();
        test_full_dump();
        test_timing(0);
        test_timing(1);
        test_robustness();
        test_reset_mid_dump();
        test_latency2();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
